// File: rtl/branch_resolver.sv
// Branch resolution stage: evaluates up to LANES conditional branches per cycle, flags the oldest
// mispredict with its correct PC, and trains a 2-bit history table. Optional BR_PERF_CNT_EN adds perf_mispred.
module branch_resolver #(
    parameter int LANES   = 2,
    parameter int XLEN    = 32,
    parameter int BHT_IDX = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic                       stall,
    input  logic [LANES-1:0]           in_valid,
    input  logic [3*LANES-1:0]         branch_type,
    input  logic [LANES-1:0]           eq,
    input  logic [LANES-1:0]           slt,
    input  logic [LANES-1:0]           ult,
    input  logic [LANES-1:0]           pred_taken,
    input  logic [BHT_IDX*LANES-1:0]   pc_idx,
    input  logic [XLEN*LANES-1:0]      target,
    input  logic [XLEN*LANES-1:0]      fallthru,
    input  logic [BHT_IDX*LANES-1:0]   lookup_idx,
    output logic [LANES-1:0]           lookup_pred,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES-1:0]           out_taken,
    output logic                       mispredict,
    output logic [XLEN-1:0]            redirect_pc
`ifdef BR_PERF_CNT_EN
    ,
    output logic [15:0]                perf_mispred
`endif
);

    localparam int ENTRIES = 2 ** BHT_IDX;

    logic [LANES-1:0]         out_valid_q, out_valid_d;
    logic [LANES-1:0]         out_taken_q, out_taken_d;
    logic                     mispredict_q, mispredict_d;
    logic [XLEN-1:0]          redirect_q, redirect_d;
    logic [BHT_IDX*LANES-1:0] idx_q;
    logic [1:0]               bht_q [ENTRIES];
    logic [1:0]               bht_d [ENTRIES];
    logic [LANES-1:0]         lane_vld;
    logic [LANES-1:0]         taken_c;
    logic                     found;

    function automatic logic eval_taken(input logic [2:0] bt, input logic e, input logic s,
                                        input logic u);
        case (bt)
            3'b000:  eval_taken = e;
            3'b001:  eval_taken = !e;
            3'b010:  eval_taken = s;
            3'b011:  eval_taken = !s;
            3'b100:  eval_taken = u;
            3'b101:  eval_taken = !u;
            default: eval_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic tk);
        if (tk) sat_update = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        else    sat_update = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    // Resolve: walk lanes oldest-first; everything younger than the first mispredict is dropped.
    always_comb begin
        lane_vld     = '0;
        taken_c      = '0;
        found        = 1'b0;
        out_valid_d  = '0;
        out_taken_d  = '0;
        mispredict_d = 1'b0;
        redirect_d   = redirect_q;
        for (int i = 0; i < LANES; i++) begin
            lane_vld[i] = in_valid[i] & ((i == 0) | !mode);
            taken_c[i]  = eval_taken(branch_type[3*i +: 3], eq[i], slt[i], ult[i]);
            if (!found && lane_vld[i]) begin
                out_valid_d[i] = 1'b1;
                out_taken_d[i] = taken_c[i];
                if (taken_c[i] != pred_taken[i]) begin
                    found        = 1'b1;
                    mispredict_d = 1'b1;
                    redirect_d   = taken_c[i] ? target[XLEN*i +: XLEN] : fallthru[XLEN*i +: XLEN];
                end
            end
        end
        // A registered mispredict means the current inputs are wrong-path work.
        if (mispredict_q) begin
            out_valid_d  = '0;
            out_taken_d  = '0;
            mispredict_d = 1'b0;
            redirect_d   = redirect_q;
        end
    end

    // History training from the registered stage; lane 0 is applied last so it wins collisions.
    always_comb begin
        bht_d = bht_q;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (out_valid_q[i])
                bht_d[idx_q[BHT_IDX*i +: BHT_IDX]] =
                    sat_update(bht_q[idx_q[BHT_IDX*i +: BHT_IDX]], out_taken_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= '0;
            out_taken_q  <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            idx_q        <= '0;
            for (int e = 0; e < ENTRIES; e++) bht_q[e] <= 2'b01;
        end else if (!stall) begin
            out_valid_q  <= out_valid_d;
            out_taken_q  <= out_taken_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            idx_q        <= pc_idx;
            bht_q        <= bht_d;
        end
    end

    always_comb begin
        lookup_pred = '0;
        for (int i = 0; i < LANES; i++)
            lookup_pred[i] = bht_q[lookup_idx[BHT_IDX*i +: BHT_IDX]][1];
    end

    assign out_valid   = out_valid_q;
    assign out_taken   = out_taken_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;

`ifdef BR_PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_q <= '0;
        else if (!stall && mispredict_q && (perf_q != 16'hFFFF))
            perf_q <= perf_q + 16'd1;
    end

    assign perf_mispred = perf_q;
`endif

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter LANES, default 2, number of branch lanes (1..4).
REQ-002 Parameter XLEN, default 32, program-counter width.
REQ-003 Parameter BHT_IDX, default 6, history-table index width (2^BHT_IDX entries).
REQ-004 Ports SHALL be as follows:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  1 = unified (lane 0 only), 0 = split (all lanes)
- stall  in  1  holds the output stage
- in_valid  in  LANES  per-lane branch present
- branch_type  in  3*LANES  000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU
- eq, slt, ult  in  LANES each  comparator flags
- pred_taken  in  LANES  front-end prediction
- pc_idx  in  BHT_IDX*LANES  history index of each branch
- target, fallthru  in  XLEN*LANES  taken and not-taken PCs
- lookup_idx  in  BHT_IDX*LANES  prediction read index
- lookup_pred  out  LANES  counter MSB at lookup_idx
- out_valid, out_taken  out  LANES  resolved branch, registered
- mispredict  out  1  registered redirect request
- redirect_pc  out  XLEN  registered correct PC

Function
REQ-005 Taken SHALL be eq, !eq, slt, !slt, ult, !ult for types 000..101, and 0 for types 110/111.
REQ-006 Latency SHALL be one cycle: inputs sampled on a rising edge with stall=0 appear on the outputs after that edge.
REQ-007 With stall=1 all output registers SHALL hold and inputs SHALL be ignored.
REQ-008 In unified mode, lanes 1..LANES-1 SHALL be treated as invalid; a mode change SHALL affect the next capture only.
REQ-009 A lane SHALL mispredict when it is valid and taken != pred_taken; lane 0 is oldest.
REQ-010 mispredict SHALL assert for the lowest-index mispredicting lane.
- redirect_pc = target if taken, else fallthru, of that lane.
- out_valid of all higher-index lanes SHALL be 0 in that cycle.
REQ-011 The capture following a registered mispredict=1 (first edge with stall=0) SHALL be forced to all-invalid (wrong-path squash).
REQ-012 redirect_pc SHALL hold its last value when mispredict=0.
REQ-013 The history table SHALL hold 2^BHT_IDX 2-bit saturating counters.
REQ-014 On each edge with stall=0, each out_valid lane SHALL update its entry: increment saturating at 11 if out_taken, else decrement saturating at 00.
- When lanes collide on one index, the lowest-index lane's update wins.
- Each resolved branch SHALL update exactly once regardless of stall length.
REQ-015 lookup_pred SHALL be combinational, returning the pre-update value (no write bypass).

Reset
REQ-016 On rst=1, immediately and independent of clk:
- out_valid, out_taken, mispredict = 0; redirect_pc = 0.
- squash flag cleared; all counters = 01 (weakly not-taken).
REQ-017 Reset asserted mid-operation SHALL discard any pending squash and updates; the first capture after deassertion SHALL be normal.

Configuration
REQ-018 With BR_PERF_CNT_EN defined, port perf_mispred (out, 16) SHALL exist, reset to 0, and increment by one on each edge with mispredict=1 and stall=0, saturating at 16'hFFFF.
REQ-019 Without BR_PERF_CNT_EN the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Unified, lane 0 BLT, slt=1, pred_taken=1, target=0x100 -> next cycle out_valid=01, out_taken=01, mispredict=0; lane 1 ignored.
- Split, lane 0 BEQ eq=0 pred 1, fallthru=0x204; lane 1 BGEU valid -> mispredict=1, redirect_pc=0x204, out_valid=01; next capture all-invalid.
- Split, both lanes correct (BNE eq=0 pred 1; BGE slt=1 pred 0) -> out_valid=11, mispredict=0.
- Three taken BEQ at pc_idx=5 -> lookup_pred[5] reads 0 after reset, then 1 after the first update; counter saturates at 11 after the second.
- Mispredict held under stall for 4 cycles -> outputs stable, counter updated once, perf_mispred +1 (macro on).
- rst pulsed asynchronously between edges while mispredict=1 -> outputs 0 immediately, lookup_pred all 0.
